eth_sd_sector_writer: RTL and testbench
=======================================

// Module: eth_sd_sector_writer
// PURPOSE
//  Read side of eth_sd_fifo: drains 32-bit Ethernet payload words (clk_ref domain) and streams them
//  into sd_ctrl_top's write port one 512-byte sector at a time, at consecutive sector addresses.
//  Sits between the FIFO read port and sd_ctrl_top wr_*. Flush pads the final partial sector.
// PARAMETERS
//  START_SECTOR  32'd2000  first SD sector address written after reset
//  LVL_W         8         width of fifo_rd_level; must hold at least 128
//  PAD_DATA      16'h0000  16-bit fill for the unfilled tail of a flushed sector
//  BUSY_TMO      24'hFFFFFF  clk_ref cycles allowed for wr_busy to rise or fall before error
// PORTS
//  clk_ref        in   1      single clock; all logic on posedge
//  rst_n          in   1      synchronous, active-low reset
//  sd_init_done   in   1      SD card initialised; no sector is started while low
//  fifo_rd_level  in   LVL_W  words available in eth_sd_fifo (read domain)
//  fifo_rd_en     out  1      FIFO read strobe; data is valid on fifo_rd_data 1 cycle later
//  fifo_rd_data   in   32     FIFO read data; the upper half is sent first
//  flush          in   1      1-cycle pulse: write the remaining words, padding the sector tail
//  wr_busy        in   1      sd_ctrl_top write in progress
//  wr_req         in   1      sd_ctrl_top requests the next 16-bit word (1-cycle pulse)
//  wr_start_en    out  1      1-cycle pulse that starts a sector write
//  wr_sec_addr    out  32     sector address, held stable from wr_start_en until wr_busy falls
//  wr_data        out  16     write word; registered, valid the cycle after wr_req
//  sector_cnt     out  32     number of sectors completed since reset
//  sector_done    out  1      1-cycle pulse when wr_busy falls at the end of a sector
//  error_flag     out  1      sticky: timeout, wr_req outside XFER, or more than 256 wr_req
// BEHAVIOUR
//  Reset: all outputs 0 except wr_sec_addr=START_SECTOR; state IDLE; flush_pend=0.
//  flush_pend is set by flush in any state and cleared on entry to WAIT_DONE of a padded sector.
//  IDLE:     go to WAIT_DATA when sd_init_done=1.
//  WAIT_DATA: level>=128 -> PREFETCH with avail=128; else if flush_pend and level>0
//            -> PREFETCH with avail=level; else if flush_pend and level=0 -> clear flush_pend.
//  PREFETCH: fifo_rd_en for 1 cycle, latch word into hold reg next cycle, words_rd=1 -> START.
//  START:    wr_start_en=1 for exactly 1 cycle -> WAIT_BUSY.
//  WAIT_BUSY: wr_busy=1 -> XFER; a timeout sets error_flag and returns to WAIT_DATA.
//  XFER:     on each wr_req, half=0: wr_data<=hold[31:16]; half=1: wr_data<=hold[15:0].
//    - If half=1 and words_rd<avail, pulse fifo_rd_en and reload hold; words_rd++.
//    - Words beyond avail are sent as PAD_DATA. half toggles; hw_cnt (9b) counts to 256.
//    - hw_cnt=256 -> WAIT_DONE; a further wr_req sets error_flag and wr_data is not updated.
//  WAIT_DONE: wr_busy=0 -> sector_done pulse, sector_cnt++, wr_sec_addr++ -> WAIT_DATA.
//    - A timeout sets error_flag and also returns to WAIT_DATA.
//  The last prefetch happens only if words_rd<avail, so the FIFO is never over-read.
//    A full sector reads exactly 128 words.
//  wr_sec_addr wraps modulo 2^32 silently. sector_cnt saturates at 32'hFFFFFFFF.
//  sd_init_done falling mid-sector: the sector completes; no new sector starts until it rises.
//  flush arriving during XFER of a full sector applies to the next sector.
//  rst_n low mid-sector: immediate return to reset values. The FIFO is not flushed by this block.
// STRUCTURE
//  State encoding (localparam), SECTOR_HW=256, SECTOR_W32=128: put in shared sd_pkg constants.
//  One sub-module is natural: sd_wr_timeout (loadable down-counter, start/clear/expired).
//    It is reused for the WAIT_BUSY and WAIT_DONE timeouts. Everything else is flat.
// TESTING
//  1 level=128 and words 0x00010002..+1, with a BFM that pulses wr_req every 32 cycles
//    -> 256 halves 0001,0002,0002,0003... in order; addr=2000; sector_cnt=1; 128 reads.
//  2 level=300 -> 2 sectors back-to-back at 2000 and 2001; 256 reads; 44 words are left in the FIFO.
//  3 level=5 with flush pulse -> 10 data halves then 246 PAD_DATA; 5 reads only; flush_pend clears.
//  4 wr_busy never rises after wr_start_en, with BUSY_TMO=100 -> error_flag=1 at cycle 101 and
//    back in WAIT_DATA; a 257th wr_req in a later test also sets error_flag.
//  5 sd_init_done=0 with level=200 -> no wr_start_en; when it rises, the sector starts
//    within 4 cycles.
//  6 rst_n low for 1 cycle at hw_cnt=100 -> all outputs at reset values the next cycle.
//    wr_sec_addr=START_SECTOR.

Source files
------------

// File: rtl/eth_sd_sector_writer_pkg.sv
// Shared constants and state encoding for the Ethernet-to-SD sector writer.
//   SECTOR_HW  : 16-bit words per 512-byte sector
//   SECTOR_W32 : 32-bit FIFO words per sector
//   wr_state_e : sector writer FSM states
package eth_sd_sector_writer_pkg;

    localparam int SECTOR_HW  = 256;
    localparam int SECTOR_W32 = 128;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_DATA = 3'd1,
        ST_PREFETCH  = 3'd2,
        ST_START     = 3'd3,
        ST_WAIT_BUSY = 3'd4,
        ST_XFER      = 3'd5,
        ST_WAIT_DONE = 3'd6
    } wr_state_e;

endpackage

// File: rtl/eth_sd_sector_writer_timeout.sv
// Loadable down-counter used to bound the wait for wr_busy to rise or fall.
// Ports:
//   clk_i     : clock
//   rst_ni    : synchronous active-low reset
//   start_i   : (re)load the counter and arm it
//   clear_i   : disarm the counter
//   expired_o : armed and TMO cycles have elapsed since start_i
module eth_sd_sector_writer_timeout #(
    parameter int          W   = 24,
    parameter logic [W-1:0] TMO = '1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic start_i,
    input  logic clear_i,
    output logic expired_o
);

    // Loading TMO-1 makes expired_o true in the TMO-th cycle after start_i,
    // so the caller reacts on exactly the TMO-th waiting cycle.
    localparam logic [W-1:0] LOAD = (TMO == '0) ? '0 : TMO - 1'b1;

    logic [W-1:0] cnt_q, cnt_d;
    logic         active_q, active_d;

    always_comb begin
        cnt_d    = cnt_q;
        active_d = active_q;
        if (start_i) begin
            cnt_d    = LOAD;
            active_d = 1'b1;
        end else if (clear_i) begin
            active_d = 1'b0;
        end else if (active_q && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    assign expired_o = active_q && (cnt_q == '0);

endmodule

// File: rtl/eth_sd_sector_writer.sv
// Drains 32-bit words from the Ethernet FIFO read port and streams them to the
// SD controller write port one 512-byte sector at a time, at consecutive
// sector addresses. A flush pulse writes the remaining words and pads the tail.
// Ports:
//   clk_ref, rst_n   : clock, synchronous active-low reset
//   sd_init_done     : card ready; gates the start of new sectors
//   fifo_rd_level    : words available in the FIFO
//   fifo_rd_en       : FIFO read strobe (data valid one cycle later)
//   fifo_rd_data     : FIFO read data, upper half sent first
//   flush            : pulse, write remaining words and pad the sector
//   wr_busy, wr_req  : SD controller write status / per-halfword request
//   wr_start_en      : pulse starting a sector write
//   wr_sec_addr      : sector address for the current/next sector
//   wr_data          : halfword answering the previous wr_req
//   sector_cnt       : saturating count of completed sectors
//   sector_done      : pulse when a sector completes
//   error_flag       : sticky protocol/timeout error
module eth_sd_sector_writer
    import eth_sd_sector_writer_pkg::*;
#(
    parameter logic [31:0] START_SECTOR = 32'd2000,
    parameter int          LVL_W        = 8,
    parameter logic [15:0] PAD_DATA     = 16'h0000,
    parameter logic [23:0] BUSY_TMO     = 24'hFFFFFF
) (
    input  logic             clk_ref,
    input  logic             rst_n,
    input  logic             sd_init_done,
    input  logic [LVL_W-1:0] fifo_rd_level,
    output logic             fifo_rd_en,
    input  logic [31:0]      fifo_rd_data,
    input  logic             flush,
    input  logic             wr_busy,
    input  logic             wr_req,
    output logic             wr_start_en,
    output logic [31:0]      wr_sec_addr,
    output logic [15:0]      wr_data,
    output logic [31:0]      sector_cnt,
    output logic             sector_done,
    output logic             error_flag
);

    wr_state_e   state_q, state_d;
    logic        flush_pend_q, flush_pend_d;
    logic [7:0]  avail_q, avail_d;
    logic [7:0]  words_rd_q, words_rd_d;
    logic        half_q, half_d;
    logic        pad_q, pad_d;
    logic [8:0]  hw_cnt_q, hw_cnt_d;
    logic        reload_q, reload_d;
    logic [31:0] hold_q, hold_d;
    logic [15:0] wr_data_q, wr_data_d;
    logic [31:0] sec_addr_q, sec_addr_d;
    logic [31:0] sector_cnt_q, sector_cnt_d;
    logic        sector_done_q, sector_done_d;
    logic        error_q, error_d;
    logic        tmo_start, tmo_clear, tmo_expired;
    logic [31:0] cur_word;

    eth_sd_sector_writer_timeout #(
        .W   (24),
        .TMO (BUSY_TMO)
    ) u_tmo (
        .clk_i     (clk_ref),
        .rst_ni    (rst_n),
        .start_i   (tmo_start),
        .clear_i   (tmo_clear),
        .expired_o (tmo_expired)
    );

    // A word read on the previous wr_req lands on fifo_rd_data this cycle;
    // forward it so a back-to-back wr_req still sees the fresh word.
    assign cur_word = reload_q ? fifo_rd_data : hold_q;

    always_comb begin
        state_d       = state_q;
        flush_pend_d  = flush_pend_q;
        avail_d       = avail_q;
        words_rd_d    = words_rd_q;
        half_d        = half_q;
        pad_d         = pad_q;
        hw_cnt_d      = hw_cnt_q;
        reload_d      = 1'b0;
        hold_d        = reload_q ? fifo_rd_data : hold_q;
        wr_data_d     = wr_data_q;
        sec_addr_d    = sec_addr_q;
        sector_cnt_d  = sector_cnt_q;
        sector_done_d = 1'b0;
        error_d       = error_q;
        fifo_rd_en    = 1'b0;
        wr_start_en   = 1'b0;
        tmo_start     = 1'b0;
        tmo_clear     = 1'b0;

        // The controller only asks for data while a sector is streaming;
        // this also catches a 257th request, which arrives in WAIT_DONE.
        if (wr_req && (state_q != ST_XFER)) begin
            error_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (sd_init_done) begin
                    state_d = ST_WAIT_DATA;
                end
            end

            ST_WAIT_DATA: begin
                if (sd_init_done && (fifo_rd_level >= LVL_W'(SECTOR_W32))) begin
                    avail_d = 8'(SECTOR_W32);
                    state_d = ST_PREFETCH;
                end else if (sd_init_done && flush_pend_q && (fifo_rd_level != '0)) begin
                    avail_d = 8'(fifo_rd_level);
                    state_d = ST_PREFETCH;
                end else if (flush_pend_q && (fifo_rd_level == '0)) begin
                    flush_pend_d = 1'b0;
                end
                words_rd_d = '0;
                half_d     = 1'b0;
                pad_d      = 1'b0;
                hw_cnt_d   = '0;
            end

            ST_PREFETCH: begin
                fifo_rd_en = 1'b1;
                reload_d   = 1'b1;
                words_rd_d = 8'd1;
                state_d    = ST_START;
            end

            ST_START: begin
                wr_start_en = 1'b1;
                tmo_start   = 1'b1;
                state_d     = ST_WAIT_BUSY;
            end

            ST_WAIT_BUSY: begin
                if (wr_busy) begin
                    tmo_clear = 1'b1;
                    state_d   = ST_XFER;
                end else if (tmo_expired) begin
                    tmo_clear = 1'b1;
                    error_d   = 1'b1;
                    state_d   = ST_WAIT_DATA;
                end
            end

            ST_XFER: begin
                if (wr_req) begin
                    hw_cnt_d = hw_cnt_q + 9'd1;
                    half_d   = ~half_q;
                    if (pad_q) begin
                        wr_data_d = PAD_DATA;
                    end else if (!half_q) begin
                        wr_data_d = cur_word[31:16];
                    end else begin
                        wr_data_d = cur_word[15:0];
                        // Fetch the next word only if one was counted as
                        // available, so the FIFO is never over-read.
                        if (words_rd_q < avail_q) begin
                            fifo_rd_en = 1'b1;
                            reload_d   = 1'b1;
                            words_rd_d = words_rd_q + 8'd1;
                        end else begin
                            pad_d = 1'b1;
                        end
                    end
                    if (hw_cnt_q == 9'(SECTOR_HW - 1)) begin
                        tmo_start = 1'b1;
                        state_d   = ST_WAIT_DONE;
                        // A short (padded) sector is what a flush produces.
                        if (avail_q != 8'(SECTOR_W32)) begin
                            flush_pend_d = 1'b0;
                        end
                    end
                end
            end

            ST_WAIT_DONE: begin
                if (!wr_busy) begin
                    tmo_clear     = 1'b1;
                    sector_done_d = 1'b1;
                    sec_addr_d    = sec_addr_q + 32'd1;
                    if (sector_cnt_q != 32'hFFFF_FFFF) begin
                        sector_cnt_d = sector_cnt_q + 32'd1;
                    end
                    state_d = ST_WAIT_DATA;
                end else if (tmo_expired) begin
                    tmo_clear = 1'b1;
                    error_d   = 1'b1;
                    state_d   = ST_WAIT_DATA;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A flush arriving in the same cycle as the clear belongs to later data.
        if (flush) begin
            flush_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk_ref) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            flush_pend_q  <= 1'b0;
            avail_q       <= '0;
            words_rd_q    <= '0;
            half_q        <= 1'b0;
            pad_q         <= 1'b0;
            hw_cnt_q      <= '0;
            reload_q      <= 1'b0;
            wr_data_q     <= '0;
            sec_addr_q    <= START_SECTOR;
            sector_cnt_q  <= '0;
            sector_done_q <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            flush_pend_q  <= flush_pend_d;
            avail_q       <= avail_d;
            words_rd_q    <= words_rd_d;
            half_q        <= half_d;
            pad_q         <= pad_d;
            hw_cnt_q      <= hw_cnt_d;
            reload_q      <= reload_d;
            wr_data_q     <= wr_data_d;
            sec_addr_q    <= sec_addr_d;
            sector_cnt_q  <= sector_cnt_d;
            sector_done_q <= sector_done_d;
            error_q       <= error_d;
        end
    end

    // Holding register carries data only; its content is irrelevant until
    // the first prefetch after reset reloads it.
    always_ff @(posedge clk_ref) begin
        hold_q <= hold_d;
    end

    assign wr_sec_addr = sec_addr_q;
    assign wr_data     = wr_data_q;
    assign sector_cnt  = sector_cnt_q;
    assign sector_done = sector_done_q;
    assign error_flag  = error_q;

endmodule

// File: tb/tb_eth_sd_sector_writer.sv
module tb_eth_sd_sector_writer;

    localparam int          LVL_W = 10;
    localparam logic [15:0] PAD   = 16'hA5A5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             sd_init_done = 1'b0;
    logic [LVL_W-1:0] fifo_rd_level = '0;
    logic             fifo_rd_en;
    logic [31:0]      fifo_rd_data = '0;
    logic             flush = 1'b0;
    logic             wr_busy = 1'b0;
    logic             wr_req = 1'b0;
    logic             wr_start_en;
    logic [31:0]      wr_sec_addr;
    logic [15:0]      wr_data;
    logic [31:0]      sector_cnt;
    logic             sector_done;
    logic             error_flag;

    int errors = 0;
    int checks = 0;

    logic [31:0] fifo_q[$];
    int          rd_total = 0;
    int          overread = 0;

    logic [15:0] got_half[0:299];
    logic [31:0] got_addr;
    bit          start_seen;
    bit          done_seen;

    eth_sd_sector_writer #(
        .START_SECTOR (32'd2000),
        .LVL_W        (LVL_W),
        .PAD_DATA     (PAD),
        .BUSY_TMO     (24'd100)
    ) dut (
        .clk_ref       (clk),
        .rst_n         (rst_n),
        .sd_init_done  (sd_init_done),
        .fifo_rd_level (fifo_rd_level),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_rd_data  (fifo_rd_data),
        .flush         (flush),
        .wr_busy       (wr_busy),
        .wr_req        (wr_req),
        .wr_start_en   (wr_start_en),
        .wr_sec_addr   (wr_sec_addr),
        .wr_data       (wr_data),
        .sector_cnt    (sector_cnt),
        .sector_done   (sector_done),
        .error_flag    (error_flag)
    );

    always #5 clk = ~clk;

    // FIFO model: one-cycle read latency, level tracks the queue occupancy.
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            if (fifo_q.size() > 0) begin
                fifo_rd_data <= fifo_q.pop_front();
                rd_total     <= rd_total + 1;
            end else begin
                overread <= overread + 1;
            end
        end
    end

    always @(negedge clk) begin
        fifo_rd_level <= LVL_W'(fifo_q.size());
    end

    // Stream value: word k = {k+1, k+2}; global halfword g comes from word g/2.
    function automatic logic [15:0] exp_half(input int g);
        int k;
        k = g / 2;
        return (g % 2 == 0) ? 16'(k + 1) : 16'(k + 2);
    endfunction

    task automatic push_seq(input int n, input int first_k);
        for (int k = first_k; k < first_k + n; k++) begin
            fifo_q.push_back({16'(k + 1), 16'(k + 2)});
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        wr_req  = 1'b0;
        wr_busy = 1'b0;
        flush   = 1'b0;
        fifo_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // SD controller model: waits for wr_start_en, raises wr_busy, issues nreq
    // wr_req pulses every 'spacing' cycles, then drops wr_busy. abort_at>0
    // returns right after that many requests with wr_busy still high.
    task automatic sd_sector(input int spacing, input int nreq, input int abort_at);
        int t;
        start_seen = 1'b0;
        done_seen  = 1'b0;
        t = 0;
        while (!wr_start_en && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!wr_start_en) return;
        start_seen = 1'b1;
        got_addr   = wr_sec_addr;
        repeat (2) @(negedge clk);
        wr_busy = 1'b1;
        for (int i = 0; i < nreq; i++) begin
            repeat (spacing - 1) @(negedge clk);
            wr_req = 1'b1;
            @(negedge clk);
            wr_req = 1'b0;
            got_half[i] = wr_data;
            if (abort_at > 0 && i + 1 == abort_at) return;
        end
        repeat (3) @(negedge clk);
        wr_busy = 1'b0;
        t = 0;
        while (!sector_done && t < 20) begin
            @(negedge clk);
            t++;
        end
        done_seen = sector_done;
    endtask

    task automatic test_reset();
        sd_init_done = 1'b0;
        do_reset();
        checks++; if (wr_start_en !== 1'b0) begin errors++; $display("FAIL reset_start got=%b exp=0", wr_start_en); end
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got=%b exp=0", fifo_rd_en); end
        checks++; if (wr_data !== 16'h0) begin errors++; $display("FAIL reset_wr_data got=%h exp=0000", wr_data); end
        checks++; if (wr_sec_addr !== 32'd2000) begin errors++; $display("FAIL reset_addr got=%0d exp=2000", wr_sec_addr); end
        checks++; if (sector_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", sector_cnt); end
        checks++; if (sector_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", sector_done); end
        checks++; if (error_flag !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", error_flag); end
    endtask

    task automatic test_single_sector();
        int rd0;
        sd_init_done = 1'b1;
        do_reset();
        rd0 = rd_total;
        push_seq(128, 0);
        sd_sector(32, 256, 0);
        checks++; if (start_seen !== 1'b1) begin errors++; $display("FAIL t1_start got=%b exp=1", start_seen); end
        checks++; if (got_addr !== 32'd2000) begin errors++; $display("FAIL t1_addr got=%0d exp=2000", got_addr); end
        for (int h = 0; h < 256; h++) begin
            checks++;
            if (got_half[h] !== exp_half(h)) begin
                errors++; $display("FAIL t1_half[%0d] got=%h exp=%h", h, got_half[h], exp_half(h));
            end
        end
        checks++; if (done_seen !== 1'b1) begin errors++; $display("FAIL t1_done got=%b exp=1", done_seen); end
        @(negedge clk);
        checks++; if (sector_cnt !== 32'd1) begin errors++; $display("FAIL t1_cnt got=%0d exp=1", sector_cnt); end
        checks++; if (wr_sec_addr !== 32'd2001) begin errors++; $display("FAIL t1_next_addr got=%0d exp=2001", wr_sec_addr); end
        checks++; if (rd_total - rd0 !== 128) begin errors++; $display("FAIL t1_reads got=%0d exp=128", rd_total - rd0); end
        checks++; if (overread !== 0) begin errors++; $display("FAIL t1_overread got=%0d exp=0", overread); end
        checks++; if (error_flag !== 1'b0) begin errors++; $display("FAIL t1_err got=%b exp=0", error_flag); end
    endtask

    task automatic test_back_to_back();
        int rd0;
        sd_init_done = 1'b1;
        do_reset();
        rd0 = rd_total;
        push_seq(300, 0);
        for (int s = 0; s < 2; s++) begin
            sd_sector(4, 256, 0);
            checks++; if (start_seen !== 1'b1) begin errors++; $display("FAIL t2_start[%0d] got=%b exp=1", s, start_seen); end
            checks++; if (got_addr !== 32'(2000 + s)) begin errors++; $display("FAIL t2_addr[%0d] got=%0d exp=%0d", s, got_addr, 2000 + s); end
            for (int h = 0; h < 256; h += 37) begin
                checks++;
                if (got_half[h] !== exp_half(256 * s + h)) begin
                    errors++; $display("FAIL t2_half[%0d][%0d] got=%h exp=%h", s, h, got_half[h], exp_half(256 * s + h));
                end
            end
            checks++; if (got_half[255] !== exp_half(256 * s + 255)) begin errors++; $display("FAIL t2_last[%0d] got=%h exp=%h", s, got_half[255], exp_half(256 * s + 255)); end
            checks++; if (done_seen !== 1'b1) begin errors++; $display("FAIL t2_done[%0d] got=%b exp=1", s, done_seen); end
        end
        repeat (20) @(negedge clk);
        checks++; if (sector_cnt !== 32'd2) begin errors++; $display("FAIL t2_cnt got=%0d exp=2", sector_cnt); end
        checks++; if (rd_total - rd0 !== 256) begin errors++; $display("FAIL t2_reads got=%0d exp=256", rd_total - rd0); end
        checks++; if (fifo_q.size() !== 44) begin errors++; $display("FAIL t2_left got=%0d exp=44", fifo_q.size()); end
    endtask

    task automatic test_flush();
        int  rd0;
        bit  extra_start;
        sd_init_done = 1'b1;
        do_reset();
        rd0 = rd_total;
        push_seq(5, 0);
        repeat (3) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        sd_sector(4, 256, 0);
        checks++; if (start_seen !== 1'b1) begin errors++; $display("FAIL t3_start got=%b exp=1", start_seen); end
        for (int h = 0; h < 256; h++) begin
            checks++;
            if (got_half[h] !== ((h < 10) ? exp_half(h) : PAD)) begin
                errors++; $display("FAIL t3_half[%0d] got=%h exp=%h", h, got_half[h], (h < 10) ? exp_half(h) : PAD);
            end
        end
        checks++; if (done_seen !== 1'b1) begin errors++; $display("FAIL t3_done got=%b exp=1", done_seen); end
        checks++; if (rd_total - rd0 !== 5) begin errors++; $display("FAIL t3_reads got=%0d exp=5", rd_total - rd0); end
        checks++; if (overread !== 0) begin errors++; $display("FAIL t3_overread got=%0d exp=0", overread); end
        // With the pending flush consumed, a few new words must not start a sector.
        push_seq(3, 0);
        extra_start = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (wr_start_en) extra_start = 1'b1;
        end
        checks++; if (extra_start !== 1'b0) begin errors++; $display("FAIL t3_flush_cleared got=%b exp=0", extra_start); end
    endtask

    task automatic test_busy_timeout();
        int t;
        sd_init_done = 1'b1;
        do_reset();
        push_seq(128, 0);
        t = 0;
        while (!wr_start_en && t < 50) begin
            @(negedge clk);
            t++;
        end
        checks++; if (wr_start_en !== 1'b1) begin errors++; $display("FAIL t4_start got=%b exp=1", wr_start_en); end
        repeat (100) @(posedge clk);
        @(negedge clk);
        checks++; if (error_flag !== 1'b0) begin errors++; $display("FAIL t4_err_c100 got=%b exp=0", error_flag); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (error_flag !== 1'b1) begin errors++; $display("FAIL t4_err_c101 got=%b exp=1", error_flag); end
        // One prefetched word is gone; topping up to 128 must restart from WAIT_DATA.
        push_seq(1, 128);
        t = 0;
        while (!wr_start_en && t < 10) begin
            @(negedge clk);
            t++;
        end
        checks++; if (wr_start_en !== 1'b1) begin errors++; $display("FAIL t4_restart got=%b exp=1", wr_start_en); end
    endtask

    task automatic test_init_gate();
        int  rd0;
        int  t;
        bit  early;
        sd_init_done = 1'b0;
        do_reset();
        rd0 = rd_total;
        push_seq(200, 0);
        early = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (wr_start_en) early = 1'b1;
        end
        checks++; if (early !== 1'b0) begin errors++; $display("FAIL t5_no_start got=%b exp=0", early); end
        checks++; if (rd_total - rd0 !== 0) begin errors++; $display("FAIL t5_no_reads got=%0d exp=0", rd_total - rd0); end
        sd_init_done = 1'b1;
        t = 0;
        while (!wr_start_en && t < 20) begin
            @(negedge clk);
            t++;
        end
        checks++; if (!(wr_start_en === 1'b1 && t <= 4)) begin errors++; $display("FAIL t5_start_delay got=%0d exp<=4", t); end
        sd_sector(4, 256, 0);
        checks++; if (done_seen !== 1'b1) begin errors++; $display("FAIL t5_done got=%b exp=1", done_seen); end
        checks++; if (got_half[0] !== exp_half(0)) begin errors++; $display("FAIL t5_half0 got=%h exp=%h", got_half[0], exp_half(0)); end
    endtask

    task automatic test_overrun();
        sd_init_done = 1'b1;
        do_reset();
        push_seq(128, 0);
        sd_sector(4, 257, 0);
        checks++; if (done_seen !== 1'b1) begin errors++; $display("FAIL t4b_done got=%b exp=1", done_seen); end
        checks++; if (got_half[255] !== exp_half(255)) begin errors++; $display("FAIL t4b_last got=%h exp=%h", got_half[255], exp_half(255)); end
        checks++; if (got_half[256] !== exp_half(255)) begin errors++; $display("FAIL t4b_held got=%h exp=%h", got_half[256], exp_half(255)); end
        @(negedge clk);
        checks++; if (error_flag !== 1'b1) begin errors++; $display("FAIL t4b_err got=%b exp=1", error_flag); end
        checks++; if (sector_cnt !== 32'd1) begin errors++; $display("FAIL t4b_cnt got=%0d exp=1", sector_cnt); end
    endtask

    task automatic test_reset_mid_sector();
        push_seq(128, 0);
        sd_sector(4, 256, 100);
        checks++; if (got_half[99] !== 16'h0033) begin errors++; $display("FAIL t6_half99 got=%h exp=0033", got_half[99]); end
        checks++; if (wr_sec_addr !== 32'd2001) begin errors++; $display("FAIL t6_pre_addr got=%0d exp=2001", wr_sec_addr); end
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (wr_data !== 16'h0) begin errors++; $display("FAIL t6_wr_data got=%h exp=0000", wr_data); end
        checks++; if (wr_sec_addr !== 32'd2000) begin errors++; $display("FAIL t6_addr got=%0d exp=2000", wr_sec_addr); end
        checks++; if (sector_cnt !== 32'd0) begin errors++; $display("FAIL t6_cnt got=%0d exp=0", sector_cnt); end
        checks++; if (error_flag !== 1'b0) begin errors++; $display("FAIL t6_err got=%b exp=0", error_flag); end
        checks++; if (sector_done !== 1'b0) begin errors++; $display("FAIL t6_done got=%b exp=0", sector_done); end
        checks++; if (wr_start_en !== 1'b0) begin errors++; $display("FAIL t6_start got=%b exp=0", wr_start_en); end
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL t6_rd_en got=%b exp=0", fifo_rd_en); end
        rst_n   = 1'b1;
        wr_busy = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_sector();
        test_back_to_back();
        test_flush();
        test_busy_timeout();
        test_init_gate();
        test_overrun();
        test_reset_mid_sector();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
